// File: rtl/mem_ctrl_pkg.sv
// Memory-controller state encoding, 5-bit display character codes and the
// state -> message lookup shared by the status display blocks.
package mem_ctrl_pkg;

  typedef enum logic [11:0] {
    StIdle      = 12'h001,
    StReadSt1   = 12'h002,
    StReadSt2   = 12'h004,
    StReadSt3   = 12'h008,
    StReadSt4   = 12'h010,
    StReadWait  = 12'h020,
    StWriteSt1  = 12'h040,
    StWriteSt2  = 12'h080,
    StWriteSt3  = 12'h100,
    StWriteSt4  = 12'h200,
    StWriteWait = 12'h400,
    StReadDone  = 12'h800
  } io_statetype;

  typedef logic [4:0] char_t;

  localparam char_t ChHex1  = 5'd1;
  localparam char_t ChHex2  = 5'd2;
  localparam char_t ChHex3  = 5'd3;
  localparam char_t ChHex4  = 5'd4;
  localparam char_t ChHexA  = 5'd10;
  localparam char_t ChHexE  = 5'd14;
  localparam char_t ChR     = 5'd16;
  localparam char_t ChD     = 5'd17;
  localparam char_t ChT     = 5'd18;
  localparam char_t ChUnd   = 5'd19;
  localparam char_t ChDash  = 5'd20;
  localparam char_t ChBlank = 5'd21;

  // "r_" plus up to 16 data nibbles
  localparam int unsigned MaxChars = 18;

  // ch[0] is the leftmost character of the message
  typedef struct packed {
    logic [4:0]                 len;
    char_t [MaxChars-1:0]       ch;
  } msg_t;

  function automatic msg_t msg6(logic [4:0] len, char_t c0, char_t c1, char_t c2,
                                char_t c3, char_t c4, char_t c5);
    msg_t m;
    m.len = len;
    for (int i = 0; i < MaxChars; i++) m.ch[i] = ChBlank;
    m.ch[0] = c0;
    m.ch[1] = c1;
    m.ch[2] = c2;
    m.ch[3] = c3;
    m.ch[4] = c4;
    m.ch[5] = c5;
    return m;
  endfunction

  function automatic msg_t msg_lookup(io_statetype st, logic [63:0] data,
                                      int unsigned nibbles);
    msg_t m;
    case (st)
      StIdle:      m = msg6(5'd4, ChHex1, ChD, ChHex1, ChHexE, ChBlank, ChBlank);
      StReadSt1:   m = msg6(5'd6, ChR, ChHexE, ChHexA, ChD, ChUnd, ChHex1);
      StReadSt2:   m = msg6(5'd6, ChR, ChHexE, ChHexA, ChD, ChUnd, ChHex2);
      StReadSt3:   m = msg6(5'd6, ChR, ChHexE, ChHexA, ChD, ChUnd, ChHex3);
      StReadSt4:   m = msg6(5'd6, ChR, ChHexE, ChHexA, ChD, ChUnd, ChHex4);
      StReadWait:  m = msg6(5'd6, ChR, ChHexE, ChHexA, ChD, ChUnd, ChDash);
      StWriteSt1:  m = msg6(5'd6, ChR, ChHex1, ChT, ChHexE, ChUnd, ChHex1);
      StWriteSt2:  m = msg6(5'd6, ChR, ChHex1, ChT, ChHexE, ChUnd, ChHex2);
      StWriteSt3:  m = msg6(5'd6, ChR, ChHex1, ChT, ChHexE, ChUnd, ChHex3);
      StWriteSt4:  m = msg6(5'd6, ChR, ChHex1, ChT, ChHexE, ChUnd, ChHex4);
      StWriteWait: m = msg6(5'd6, ChR, ChHex1, ChT, ChHexE, ChUnd, ChDash);
      StReadDone: begin
        m = msg6(5'(nibbles + 2), ChR, ChUnd, ChBlank, ChBlank, ChBlank, ChBlank);
        for (int i = 0; i < MaxChars - 2; i++) begin
          if (i < nibbles) m.ch[i+2] = {1'b0, 4'(data >> (4 * (nibbles - 1 - i)))};
        end
      end
      default:     m = msg6(5'd3, ChD, ChHex1, ChHexE, ChBlank, ChBlank, ChBlank);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hex_driver.sv
// 5-bit character code to active-low 7-segment pattern; bit 7 is DP (off here).
module hex_driver
  import mem_ctrl_pkg::*;
(
  input  logic [4:0] char_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = 8'hFF;
    case (char_i)
      5'd0:    seg_o = 8'hC0;
      5'd1:    seg_o = 8'hF9;
      5'd2:    seg_o = 8'hA4;
      5'd3:    seg_o = 8'hB0;
      5'd4:    seg_o = 8'h99;
      5'd5:    seg_o = 8'h92;
      5'd6:    seg_o = 8'h82;
      5'd7:    seg_o = 8'hF8;
      5'd8:    seg_o = 8'h80;
      5'd9:    seg_o = 8'h90;
      5'd10:   seg_o = 8'h88;
      5'd11:   seg_o = 8'h83;
      5'd12:   seg_o = 8'hC6;
      5'd13:   seg_o = 8'hA1;
      5'd14:   seg_o = 8'h86;
      5'd15:   seg_o = 8'h8E;
      ChR:     seg_o = 8'hAF;
      ChD:     seg_o = 8'hA1;
      ChT:     seg_o = 8'h87;
      ChUnd:   seg_o = 8'hF7;
      ChDash:  seg_o = 8'hBF;
      default: seg_o = 8'hFF;
    endcase
  end

endmodule

// File: rtl/hex_status_scroller.sv
// Registered status display: shows controller state / held read data on 7-seg
// digits, scrolling long messages and blinking during wait states.
module hex_status_scroller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SCROLL_DIV = 12500000,
  parameter int unsigned BLINK_DIV  = 6250000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  io_statetype             state,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic                    rd_valid,
  output logic [NUM_DIGITS*8-1:0] hex_out,
  output logic [DATA_W-1:0]       held_val
);

  localparam int unsigned SpW = $clog2(SCROLL_DIV);
  localparam int unsigned BpW = $clog2(BLINK_DIV);

  io_statetype             prev_q;
  logic [DATA_W-1:0]       held_q, held_d;
  logic [SpW-1:0]          sp_q, sp_d;
  logic [BpW-1:0]          bp_q, bp_d;
  logic [4:0]              off_q, off_d;
  logic                    phase_q, phase_d;
  logic                    cap_q, cap_d;
  logic [NUM_DIGITS*8-1:0] hex_q, hex_d;

  msg_t       msg;
  logic [4:0] period;
  logic       scroll, is_wait, chg, dp;
  char_t      digit_ch [NUM_DIGITS];
  logic [7:0] seg      [NUM_DIGITS];

  // Rendered from post-edge values so a new state or capture shows on the next edge
  assign msg     = msg_lookup(state, 64'(held_d), DATA_W / 4);
  assign period  = msg.len + 5'd2;
  assign scroll  = msg.len > 5'(NUM_DIGITS);
  assign is_wait = (state == StReadWait) || (state == StWriteWait);
  assign chg     = state != prev_q;
  assign dp      = (state == StReadDone) && cap_d;

  always_comb begin
    held_d  = rd_valid ? rd_data : held_q;
    cap_d   = rd_valid | (cap_q & ~chg);
    sp_d    = sp_q;
    off_d   = off_q;
    bp_d    = bp_q;
    phase_d = phase_q;
    if (chg) begin
      sp_d    = '0;
      off_d   = '0;
      bp_d    = '0;
      phase_d = 1'b0;
    end else begin
      if (scroll) begin
        if (sp_q == SpW'(SCROLL_DIV - 1)) begin
          sp_d  = '0;
          off_d = (off_q == period - 5'd1) ? 5'd0 : off_q + 5'd1;
        end else begin
          sp_d = sp_q + SpW'(1);
        end
      end else begin
        sp_d  = '0;
        off_d = '0;
      end
      if (is_wait) begin
        if (bp_q == BpW'(BLINK_DIV - 1)) begin
          bp_d    = '0;
          phase_d = ~phase_q;
        end else begin
          bp_d = bp_q + BpW'(1);
        end
      end else begin
        bp_d    = '0;
        phase_d = 1'b0;
      end
    end
  end

  // Digit k shows message position NUM_DIGITS-1-k (digit 0 is rightmost)
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      logic [5:0] pos;
      pos = 6'(off_d) + 6'(NUM_DIGITS - 1 - k);
      if (scroll && pos >= 6'(period)) pos = pos - 6'(period);
      if (phase_d || pos >= 6'(msg.len)) digit_ch[k] = ChBlank;
      else                               digit_ch[k] = msg.ch[pos[4:0]];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
    hex_driver u_hex_driver (
      .char_i (digit_ch[g]),
      .seg_o  (seg[g])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) hex_d[8*k +: 8] = seg[k];
    if (dp) hex_d[7] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= StIdle;
      held_q  <= '0;
      sp_q    <= '0;
      bp_q    <= '0;
      off_q   <= '0;
      phase_q <= 1'b0;
      cap_q   <= 1'b0;
      hex_q   <= '1;
    end else begin
      prev_q  <= state;
      held_q  <= held_d;
      sp_q    <= sp_d;
      bp_q    <= bp_d;
      off_q   <= off_d;
      phase_q <= phase_d;
      cap_q   <= cap_d;
      hex_q   <= hex_d;
    end
  end

  assign hex_out  = hex_q;
  assign held_val = held_q;

endmodule

// File: tb/tb_hex_status_scroller.sv
// Bench for hex_status_scroller: a 16-bit (static READ_DONE) and a 32-bit
// (scrolling READ_DONE) instance checked against a string-level display model.
module tb_hex_status_scroller;
  import mem_ctrl_pkg::*;

  localparam int SDIV = 4;
  localparam int BDIV = 3;

  logic        clk = 1'b0;
  logic        rst;
  io_statetype state;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [47:0] hex_a, hex_b;
  logic [15:0] held_a;
  logic [31:0] held_b;

  int checks = 0;
  int errors = 0;

  // model state
  io_statetype m_prev;
  logic [31:0] m_held;
  logic        m_cap;
  int          m_k;
  logic [47:0] exp_a, exp_b;

  always #5 clk = ~clk;

  hex_status_scroller #(
    .NUM_DIGITS (6),
    .DATA_W     (16),
    .SCROLL_DIV (SDIV),
    .BLINK_DIV  (BDIV)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .rd_data  (rd_data[15:0]),
    .rd_valid (rd_valid),
    .hex_out  (hex_a),
    .held_val (held_a)
  );

  hex_status_scroller #(
    .NUM_DIGITS (6),
    .DATA_W     (32),
    .SCROLL_DIV (SDIV),
    .BLINK_DIV  (BDIV)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .hex_out  (hex_b),
    .held_val (held_b)
  );

  function automatic logic [7:0] seg_of(byte c);
    case (c)
      "0": return 8'hC0;  "1": return 8'hF9;  "2": return 8'hA4;  "3": return 8'hB0;
      "4": return 8'h99;  "5": return 8'h92;  "6": return 8'h82;  "7": return 8'hF8;
      "8": return 8'h80;  "9": return 8'h90;  "a": return 8'h88;  "b": return 8'h83;
      "c": return 8'hC6;  "d": return 8'hA1;  "e": return 8'h86;  "f": return 8'h8E;
      "A": return 8'h88;  "E": return 8'h86;  "r": return 8'hAF;  "t": return 8'h87;
      "_": return 8'hF7;  "-": return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic string msg_of(io_statetype st, logic [31:0] held, int nib);
    case (st)
      StIdle:      return "1d1E";
      StReadSt1:   return "rEAd_1";
      StReadSt2:   return "rEAd_2";
      StReadSt3:   return "rEAd_3";
      StReadSt4:   return "rEAd_4";
      StReadWait:  return "rEAd_-";
      StWriteSt1:  return "r1tE_1";
      StWriteSt2:  return "r1tE_2";
      StWriteSt3:  return "r1tE_3";
      StWriteSt4:  return "r1tE_4";
      StWriteWait: return "r1tE_-";
      StReadDone:
        if (nib == 4) return {"r_", $sformatf("%h", held[15:0])};
        else          return {"r_", $sformatf("%h", held)};
      default:     return "d1E";
    endcase
  endfunction

  // k = clock edges since the state was entered (0 on the entry edge)
  function automatic logic [47:0] frame(io_statetype st, logic [31:0] held, int nib, int k,
                                        logic cap);
    string       m;
    int          len;
    logic [47:0] f;
    m   = msg_of(st, held, nib);
    len = m.len();
    for (int j = 0; j < 6; j++) begin
      byte c;
      if (len <= 6) begin
        c = (j < len) ? m[j] : " ";
      end else begin
        int p, idx;
        p   = len + 2;
        idx = ((k / SDIV) % p + j) % p;
        c   = (idx < len) ? m[idx] : " ";
      end
      if ((st == StReadWait || st == StWriteWait) && ((k / BDIV) % 2 == 1)) c = " ";
      f[8*(5-j) +: 8] = seg_of(c);
    end
    if (st == StReadDone && cap) f[7] = 1'b0;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_prev = StIdle;
      m_held = '0;
      m_cap  = 1'b0;
      m_k    = 0;
      exp_a  = '1;
      exp_b  = '1;
    end else begin
      m_k    = (state != m_prev) ? 0 : m_k + 1;
      m_cap  = rd_valid || (m_cap && state == m_prev);
      if (rd_valid) m_held = rd_data;
      m_prev = state;
      exp_a  = frame(state, m_held, 4, m_k, m_cap);
      exp_b  = frame(state, m_held, 8, m_k, m_cap);
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks += 4;
    if (hex_a !== '1) begin errors++; $display("FAIL reset_hex_a got=%h exp=all-ones", hex_a); end
    if (hex_b !== '1) begin errors++; $display("FAIL reset_hex_b got=%h exp=all-ones", hex_b); end
    if (held_a !== '0) begin errors++; $display("FAIL reset_held_a got=%h exp=0", held_a); end
    if (held_b !== '0) begin errors++; $display("FAIL reset_held_b got=%h exp=0", held_b); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks += 2;
    if (hex_a !== 48'hF9A1F986FFFF) begin
      errors++; $display("FAIL idle_a got=%h exp=%h", hex_a, 48'hF9A1F986FFFF);
    end
    if (hex_b !== exp_b) begin errors++; $display("FAIL idle_b got=%h exp=%h", hex_b, exp_b); end
  endtask

  task automatic test_read_st();
    state = StReadSt1;
    tick();
    checks++;
    if (hex_a !== 48'hAF8688A1F7F9) begin
      errors++; $display("FAIL read_st1 got=%h exp=%h", hex_a, 48'hAF8688A1F7F9);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks += 2;
      if (hex_a !== exp_a) begin errors++; $display("FAIL read_st_a i=%0d got=%h exp=%h", i, hex_a, exp_a); end
      if (hex_b !== exp_b) begin errors++; $display("FAIL read_st_b i=%0d got=%h exp=%h", i, hex_b, exp_b); end
    end
  endtask

  task automatic test_read_done();
    state    = StReadDone;
    rd_data  = 32'h1234BEEF;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    checks += 4;
    if (hex_a !== 48'hAFF78386860E) begin
      errors++; $display("FAIL done_beef got=%h exp=%h", hex_a, 48'hAFF78386860E);
    end
    if (hex_b !== exp_b) begin errors++; $display("FAIL done_b got=%h exp=%h", hex_b, exp_b); end
    if (held_a !== 16'hBEEF) begin errors++; $display("FAIL held_a got=%h exp=%h", held_a, 16'hBEEF); end
    if (held_b !== 32'h1234BEEF) begin
      errors++; $display("FAIL held_b got=%h exp=%h", held_b, 32'h1234BEEF);
    end
  endtask

  task automatic test_scroll();
    // full 48-cycle wrap plus a capture mid-scroll that must not reset the offset
    for (int i = 0; i < 56; i++) begin
      if (i == 30) begin
        rd_data  = $urandom;
        rd_valid = 1'b1;
      end
      tick();
      rd_valid = 1'b0;
      checks += 3;
      if (hex_a !== exp_a) begin errors++; $display("FAIL scroll_a i=%0d got=%h exp=%h", i, hex_a, exp_a); end
      if (hex_b !== exp_b) begin errors++; $display("FAIL scroll_b i=%0d got=%h exp=%h", i, hex_b, exp_b); end
      if (held_b !== m_held) begin errors++; $display("FAIL scroll_held i=%0d got=%h exp=%h", i, held_b, m_held); end
    end
    state = StReadSt2;
    tick();
    state = StReadDone;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 2;
      if (hex_a !== exp_a) begin errors++; $display("FAIL reenter_a i=%0d got=%h exp=%h", i, hex_a, exp_a); end
      if (hex_b !== exp_b) begin errors++; $display("FAIL reenter_b i=%0d got=%h exp=%h", i, hex_b, exp_b); end
    end
  endtask

  task automatic test_blink();
    state = StReadWait;
    for (int i = 0; i < 14; i++) begin
      tick();
      checks += 2;
      if (hex_a !== exp_a) begin errors++; $display("FAIL blink_a i=%0d got=%h exp=%h", i, hex_a, exp_a); end
      if (hex_b !== exp_b) begin errors++; $display("FAIL blink_b i=%0d got=%h exp=%h", i, hex_b, exp_b); end
    end
    state = StReadDone;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (hex_a !== exp_a) begin errors++; $display("FAIL solid_a i=%0d got=%h exp=%h", i, hex_a, exp_a); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    d        = $urandom;
    state    = io_statetype'(12'h000);
    rd_data  = d;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    checks += 3;
    if (hex_a !== 48'hA1F986FFFFFF) begin
      errors++; $display("FAIL illegal_a got=%h exp=%h", hex_a, 48'hA1F986FFFFFF);
    end
    if (hex_b !== exp_b) begin errors++; $display("FAIL illegal_b got=%h exp=%h", hex_b, exp_b); end
    if (held_b !== d) begin errors++; $display("FAIL illegal_held got=%h exp=%h", held_b, d); end
  endtask

  task automatic test_midscroll_reset();
    state    = StReadDone;
    rd_data  = $urandom;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    #1;
    checks += 2;
    if (hex_b !== '1) begin errors++; $display("FAIL midreset_hex got=%h exp=all-ones", hex_b); end
    if (held_b !== '0) begin errors++; $display("FAIL midreset_held got=%h exp=0", held_b); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks += 2;
      if (hex_a !== exp_a) begin errors++; $display("FAIL resume_a i=%0d got=%h exp=%h", i, hex_a, exp_a); end
      if (hex_b !== exp_b) begin errors++; $display("FAIL resume_b i=%0d got=%h exp=%h", i, hex_b, exp_b); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) begin
        int r;
        r     = $urandom_range(12, 0);
        state = io_statetype'((r == 12) ? 12'h000 : (12'h001 << r));
      end
      rd_valid = ($urandom_range(7, 0) == 0);
      rd_data  = $urandom;
      tick();
      checks += 4;
      if (hex_a !== exp_a) begin errors++; $display("FAIL rand_a i=%0d got=%h exp=%h", i, hex_a, exp_a); end
      if (hex_b !== exp_b) begin errors++; $display("FAIL rand_b i=%0d got=%h exp=%h", i, hex_b, exp_b); end
      if (held_a !== m_held[15:0]) begin
        errors++; $display("FAIL rand_held_a i=%0d got=%h exp=%h", i, held_a, m_held[15:0]);
      end
      if (held_b !== m_held) begin
        errors++; $display("FAIL rand_held_b i=%0d got=%h exp=%h", i, held_b, m_held);
      end
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    state    = StIdle;
    rd_data  = '0;
    rd_valid = 1'b0;
    m_prev   = StIdle;
    m_held   = '0;
    m_cap    = 1'b0;
    m_k      = 0;
    exp_a    = '1;
    exp_b    = '1;
    test_reset();
    test_read_st();
    test_read_done();
    test_scroll();
    test_blink();
    test_illegal();
    test_midscroll_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
